freelist: RTL and testbench

- Physical-register allocator for the rename/dispatch stage.
- Holds all unmapped physical registers in a circular FIFO and hands up to SUPERSCALAR_WAYS tags per cycle to dispatch.
- Reclaims told tags from ROB retirement.
- Restores allocation state on a branch mispredict flush, so dispatch never needs a walk-back.

---
 rtl/freelist_pkg.sv | 30 +++
 rtl/freelist_prefix_count.sv | 18 +
 rtl/freelist.sv | 115 +++++++++++
 tb/tb_freelist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_pkg.sv
// Shared constants and stage bundles for the
// physical-register free list.
package freelist_pkg;
  localparam int SUPERSCALAR_WAYS = 3;
  localparam int N_PHYS_REG = 64;
  localparam int N_ARCH_REG = 32;
  localparam int N_PHYS_REG_BITS = 6;
  localparam int FL_DEPTH_BITS = 5;
  localparam int FL_DEPTH = N_PHYS_REG - N_ARCH_REG;

  typedef logic [N_PHYS_REG_BITS-1:0] pr_tag_t;

  localparam pr_tag_t ZERO_REG = '0;

  typedef struct packed {
    pr_tag_t [SUPERSCALAR_WAYS-1:0] t_idx;
    logic [SUPERSCALAR_WAYS-1:0] stall;
    logic [FL_DEPTH_BITS:0] free_count;
  } freelist_dispatch_packet_t;

  typedef struct packed {
    logic [SUPERSCALAR_WAYS-1:0] new_pr_en;
  } dispatch_freelist_packet_t;

  typedef struct packed {
    logic [SUPERSCALAR_WAYS-1:0] retire_en;
    logic [SUPERSCALAR_WAYS-1:0] retire_has_dest;
    pr_tag_t [SUPERSCALAR_WAYS-1:0] retire_told_idx;
  } rob_freelist_packet_t;
endpackage

// File: rtl/freelist_prefix_count.sv
// Population count plus exclusive prefix sums
// over a small request vector.
module prefix_count #(
  parameter int W = 3,
  parameter int CW = 2
) (
  input  logic [W-1:0]         bits,
  output logic [W-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);
  always_comb begin
    total = '0;
    for (int k = 0; k < W; k++) begin
      prefix[k] = total;
      total = total + CW'(bits[k]);
    end
  end
endmodule

// File: rtl/freelist.sv
// Circular free list of physical tags with
// retire reclaim and flush restore.
import freelist_pkg::*;

module freelist (
  input  logic clock,
  input  logic reset,
  input  logic branch_flush_en,
  input  logic [SUPERSCALAR_WAYS-1:0] new_pr_en,
  input  logic [SUPERSCALAR_WAYS-1:0] retire_en,
  input  logic [SUPERSCALAR_WAYS-1:0] retire_has_dest,
  input  logic [SUPERSCALAR_WAYS-1:0]
               [N_PHYS_REG_BITS-1:0] retire_told_idx,
  output logic [SUPERSCALAR_WAYS-1:0]
               [N_PHYS_REG_BITS-1:0] t_idx,
  output logic [SUPERSCALAR_WAYS-1:0] stall,
  output logic [FL_DEPTH_BITS:0] free_count
);
  localparam int W = SUPERSCALAR_WAYS;
  localparam int CW = FL_DEPTH_BITS + 1;

  typedef logic [CW-1:0] ptr_t;
  typedef logic [FL_DEPTH_BITS-1:0] idx_t;

  pr_tag_t entry [FL_DEPTH];
  ptr_t head, rhead, tail;
  ptr_t count, n_alloc, alloc_req;
  ptr_t n_free, n_ret;
  ptr_t head_next, rhead_next, tail_next;
  logic [W-1:0] free_mask, dest_mask;
  logic [W-1:0][CW-1:0] free_off;
  logic [W-1:0][CW-1:0] alloc_pre;
  logic [W-1:0][CW-1:0] ret_pre;
  logic unused_pre;

  dispatch_freelist_packet_t disp;
  rob_freelist_packet_t rob;
  freelist_dispatch_packet_t fl_out;

  assign disp.new_pr_en = new_pr_en;
  assign rob.retire_en = retire_en;
  assign rob.retire_has_dest = retire_has_dest;
  assign rob.retire_told_idx = retire_told_idx;

  assign dest_mask = rob.retire_en
                   & rob.retire_has_dest;

  always_comb begin
    free_mask = '0;
    for (int k = 0; k < W; k++)
      free_mask[k] = dest_mask[k] &
        (rob.retire_told_idx[k] != ZERO_REG);
  end

  prefix_count #(.W(W), .CW(CW)) u_free (
    .bits   (free_mask),
    .prefix (free_off),
    .total  (n_free)
  );

  prefix_count #(.W(W), .CW(CW)) u_alloc (
    .bits   (disp.new_pr_en),
    .prefix (alloc_pre),
    .total  (alloc_req)
  );

  prefix_count #(.W(W), .CW(CW)) u_ret (
    .bits   (dest_mask),
    .prefix (ret_pre),
    .total  (n_ret)
  );

  assign unused_pre = ^{alloc_pre, ret_pre};

  // Wrap bits make tail-head exact in 0..DEPTH.
  assign count = tail - head;
  assign n_alloc = branch_flush_en ? '0 :
                   (alloc_req > count) ? count :
                   alloc_req;
  assign rhead_next = rhead + n_ret;
  assign head_next = branch_flush_en ? rhead_next
                                     : head + n_alloc;
  assign tail_next = tail + n_free;

  always_comb begin
    fl_out.free_count = count;
    for (int k = 0; k < W; k++) begin
      fl_out.t_idx[k] =
        entry[idx_t'(head + ptr_t'(k))];
      fl_out.stall[k] = (count <= ptr_t'(k));
    end
  end

  assign t_idx = fl_out.t_idx;
  assign stall = fl_out.stall;
  assign free_count = fl_out.free_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entry[i] <= pr_tag_t'(N_ARCH_REG + i);
      head <= '0;
      rhead <= '0;
      tail <= ptr_t'(FL_DEPTH);
    end else begin
      head <= head_next;
      rhead <= rhead_next;
      tail <= tail_next;
      for (int k = 0; k < W; k++)
        if (free_mask[k])
          entry[idx_t'(tail + free_off[k])] <=
            rob.retire_told_idx[k];
    end
  end
endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench: queue-level free list model
// vs. the freelist RTL.
module tb_freelist;
  import freelist_pkg::*;

  localparam int W = SUPERSCALAR_WAYS;
  localparam int D = N_PHYS_REG - N_ARCH_REG;

  typedef logic [W-1:0][N_PHYS_REG_BITS-1:0] tags_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic branch_flush_en = 1'b0;
  logic [W-1:0] new_pr_en = '0;
  logic [W-1:0] retire_en = '0;
  logic [W-1:0] retire_has_dest = '0;
  tags_t retire_told_idx = '0;
  tags_t t_idx;
  logic [W-1:0] stall;
  logic [FL_DEPTH_BITS:0] free_count;

  always #5 clock = ~clock;

  freelist dut (
    .clock           (clock),
    .reset           (reset),
    .branch_flush_en (branch_flush_en),
    .new_pr_en       (new_pr_en),
    .retire_en       (retire_en),
    .retire_has_dest (retire_has_dest),
    .retire_told_idx (retire_told_idx),
    .t_idx           (t_idx),
    .stall           (stall),
    .free_count      (free_count)
  );

  typedef struct {
    int fc;
    int t[W];
  } exp_t;

  exp_t exp_q[$];
  int fl[$];
  int spec[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input int req);
    n_vec++;
    if (act !== 32'(req)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("free_count", 32'(free_count), e.fc);
        for (int k = 0; k < W; k++) begin
          chk($sformatf("stall[%0d]", k),
              32'(stall[k]), (e.fc <= k) ? 1 : 0);
          if (k < e.fc)
            chk($sformatf("t_idx[%0d]", k),
                32'(t_idx[k]), e.t[k]);
        end
      end
    end
  end

  task automatic step(input logic rst,
                      input logic fls,
                      input logic [W-1:0] en,
                      input logic [W-1:0] ren,
                      input logic [W-1:0] rhd,
                      input tags_t told);
    exp_t e;
    int na;
    @(negedge clock);
    reset = rst;
    branch_flush_en = fls;
    new_pr_en = en;
    retire_en = ren;
    retire_has_dest = rhd;
    retire_told_idx = told;
    if (rst) begin
      fl.delete();
      spec.delete();
      for (int i = 0; i < D; i++)
        fl.push_back(N_ARCH_REG + i);
    end else begin
      for (int k = 0; k < W; k++)
        if (ren[k] && rhd[k] && spec.size() > 0)
          void'(spec.pop_front());
      if (fls) begin
        while (spec.size() > 0)
          fl.push_front(spec.pop_back());
      end else begin
        na = $countones(en);
        if (na > fl.size()) begin
          n_bad++;
          $display("FAIL alloc_protocol: req %0d, free %0d",
                   na, fl.size());
        end
        for (int k = 0; k < W; k++)
          if (en[k] && fl.size() > 0)
            spec.push_back(fl.pop_front());
      end
      for (int k = 0; k < W; k++)
        if (ren[k] && rhd[k] && told[k] != 0)
          fl.push_back(int'(told[k]));
    end
    e.fc = fl.size();
    for (int k = 0; k < W; k++)
      e.t[k] = (k < fl.size()) ? fl[k] : 0;
    exp_q.push_back(e);
  endtask

  task automatic alloc(input logic [W-1:0] en);
    step(1'b0, 1'b0, en, '0, '0, '0);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin : driver
    tags_t told;
    logic f;
    logic [W-1:0] en, ren, rhd;
    int nret, room, nfl;

    step(1'b1, 1'b0, '0, '0, '0, '0);
    settle();
    chk("reset_fc", 32'(free_count), 32);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_t0", 32'(t_idx[0]), 32);
    chk("reset_t2", 32'(t_idx[2]), 34);
    alloc(3'b111);
    settle();
    chk("a3_t0", 32'(t_idx[0]), 35);
    chk("a3_t2", 32'(t_idx[2]), 37);
    chk("a3_fc", 32'(free_count), 29);

    step(1'b1, 1'b0, '0, '0, '0, '0);
    alloc(3'b101);
    settle();
    chk("a101_t0", 32'(t_idx[0]), 34);

    step(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (10) alloc(3'b111);
    alloc(3'b011);
    settle();
    chk("empty_fc", 32'(free_count), 0);
    chk("empty_stall", 32'(stall), 7);
    told = '0;
    told[0] = 6'd5;
    told[1] = 6'd9;
    step(1'b0, 1'b0, '0, 3'b011, 3'b011, told);
    settle();
    chk("refill_fc", 32'(free_count), 2);
    chk("refill_t0", 32'(t_idx[0]), 5);
    chk("refill_t1", 32'(t_idx[1]), 9);
    chk("refill_stall", 32'(stall), 4);

    step(1'b1, 1'b0, '0, '0, '0, '0);
    repeat (9) alloc(3'b111);
    alloc(3'b001);
    told = '0;
    told[0] = 6'd7;
    step(1'b0, 1'b0, 3'b111, 3'b001, 3'b001, told);
    settle();
    chk("sim_fc", 32'(free_count), 2);
    chk("sim_t0", 32'(t_idx[0]), 63);
    chk("sim_t1", 32'(t_idx[1]), 7);

    step(1'b1, 1'b0, '0, '0, '0, '0);
    alloc(3'b111);
    alloc(3'b111);
    told = '0;
    told[0] = 6'd3;
    step(1'b0, 1'b1, 3'b111, 3'b001, 3'b001, told);
    settle();
    chk("flush_t0", 32'(t_idx[0]), 33);
    chk("flush_fc", 32'(free_count), 32);

    step(1'b1, 1'b0, '0, '0, '0, '0);
    for (int c = 0; c < 3000; c++) begin
      f = ($urandom_range(15) == 0);
      ren = W'($urandom);
      rhd = W'($urandom);
      nret = 0;
      for (int k = 0; k < W; k++)
        if (ren[k] && rhd[k]) begin
          if (nret < spec.size()) nret++;
          else rhd[k] = 1'b0;
        end
      room = D - (fl.size() + spec.size() - nret);
      for (int k = 0; k < W; k++) begin
        told[k] = ($urandom_range(9) == 0) ? 6'd0 :
          6'($urandom_range(N_PHYS_REG - 1, 1));
        if (ren[k] && rhd[k] && told[k] != 0) begin
          if (room > 0) room--;
          else told[k] = 6'd0;
        end
      end
      en = W'($urandom);
      nfl = fl.size();
      for (int k = 0; k < W; k++)
        if (en[k]) begin
          if (nfl > 0) nfl--;
          else en[k] = 1'b0;
        end
      step(1'b0, f, en, ren, rhd, told);
    end

    step(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clock);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
